// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALUOp encodings and the control bundle shared by the decode stage
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic alu_src;
    logic reg_dst;
    logic [1:0] alu_op;
    logic branch;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic reg_write;
    logic illegal;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin c.reg_dst = 1'b1; c.alu_op = ALUOP_FUNCT; c.reg_write = 1'b1; end
      OP_LW: begin c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.alu_op = ALUOP_ADD; end
      OP_SW: begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.alu_op = ALUOP_ADD; end
      OP_BEQ: begin c.branch = 1'b1; c.alu_op = ALUOP_SUB; end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF/ID input, write-back, stall and ID/EX output bundle of the decode stage
interface id_stage_pipe_if #(parameter int XLEN = 32, parameter int AW = 5);
  logic [31:0] id_inst;
  logic id_valid;
  logic flush;
  logic wb_regWrite;
  logic [AW-1:0] wb_writeReg;
  logic [XLEN-1:0] wb_writeData;
  logic stall;
  logic ex_valid;
  logic [XLEN-1:0] ex_regData1;
  logic [XLEN-1:0] ex_regData2;
  logic [XLEN-1:0] ex_ext_immed;
  logic [5:0] ex_funct;
  logic [AW-1:0] ex_rs;
  logic [AW-1:0] ex_rt;
  logic [AW-1:0] ex_rd;
  logic ex_ALUSrc;
  logic ex_RegDst;
  logic [1:0] ex_ALUOp;
  logic ex_branch;
  logic ex_MemWrite;
  logic ex_MemRead;
  logic ex_MemtoReg;
  logic ex_regWrite;
  logic ex_illegal;
  modport master (
    output id_inst, id_valid, flush, wb_regWrite, wb_writeReg, wb_writeData,
    input stall, ex_valid, ex_regData1, ex_regData2, ex_ext_immed, ex_funct, ex_rs, ex_rt, ex_rd,
    input ex_ALUSrc, ex_RegDst, ex_ALUOp, ex_branch, ex_MemWrite, ex_MemRead, ex_MemtoReg, ex_regWrite, ex_illegal
  );
  modport slave (
    input id_inst, id_valid, flush, wb_regWrite, wb_writeReg, wb_writeData,
    output stall, ex_valid, ex_regData1, ex_regData2, ex_ext_immed, ex_funct, ex_rs, ex_rt, ex_rd,
    output ex_ALUSrc, ex_RegDst, ex_ALUOp, ex_branch, ex_MemWrite, ex_MemRead, ex_MemtoReg, ex_regWrite, ex_illegal
  );
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass: 2R/1W register file with optional same-cycle write-to-read bypass
module regfile_bypass #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter bit BYPASS_EN = 1'b1,
  parameter bit R0_ZERO = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [XLEN-1:0] wdata,
  input logic [AW-1:0] raddr1,
  input logic [AW-1:0] raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  logic [XLEN-1:0] mem_q [2**AW];
  logic [XLEN-1:0] mem_d [2**AW];
  logic wr_en;
  assign wr_en = we & ~(R0_ZERO & (waddr == '0));
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  // wr_en already excludes register 0 when it is hardwired, so the bypass never leaks into it
  assign rdata1 = (BYPASS_EN && wr_en && raddr1 == waddr) ? wdata : (R0_ZERO && raddr1 == '0) ? '0 : mem_q[raddr1];
  assign rdata2 = (BYPASS_EN && wr_en && raddr2 == waddr) ? wdata : (R0_ZERO && raddr2 == '0) ? '0 : mem_q[raddr2];
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage with regfile, load-use stall, flush and ID/EX register
module id_stage_pipe
  import mips_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter bit BYPASS_EN = 1'b1,
  parameter bit R0_ZERO = 1'b1
) (
  input logic clk,
  input logic rst,
  id_stage_pipe_if.slave bus
);
  logic [5:0] op;
  logic [AW-1:0] rs, rt, rd;
  logic [XLEN-1:0] rdata1, rdata2, imm;
  logic uses_rt, hz, stall, take;
  logic unused_shamt;
  logic valid_d, valid_q;
  logic [XLEN-1:0] rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
  logic [5:0] funct_d, funct_q;
  logic [AW-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  ctrl_t ctrl_d, ctrl_q;
  assign op = bus.id_inst[31:26];
  assign rs = AW'(bus.id_inst[25:21]);
  assign rt = AW'(bus.id_inst[20:16]);
  assign rd = AW'(bus.id_inst[15:11]);
  assign imm = XLEN'($signed(bus.id_inst[15:0]));
  assign unused_shamt = ^bus.id_inst[10:6];
  regfile_bypass #(.XLEN(XLEN), .AW(AW), .BYPASS_EN(BYPASS_EN), .R0_ZERO(R0_ZERO)) u_rf (
    .clk(clk),
    .rst(rst),
    .we(bus.wb_regWrite),
    .waddr(bus.wb_writeReg),
    .wdata(bus.wb_writeData),
    .raddr1(rs),
    .raddr2(rt),
    .rdata1(rdata1),
    .rdata2(rdata2)
  );
  // the bubble clears ctrl_q.mem_read, so a load can stall its consumer only once
  assign uses_rt = (op == OP_RTYPE) | (op == OP_SW) | (op == OP_BEQ);
  assign hz = valid_q & ctrl_q.mem_read & (|rt_q) & bus.id_valid & ((rt_q == rs) | (uses_rt & (rt_q == rt)));
  assign stall = hz & ~bus.flush & ~rst;
  always_comb begin
    take = bus.id_valid & ~bus.flush & ~stall;
    valid_d = take;
    ctrl_d = take ? decode_ctrl(op) : CTRL_NOP;
    rd1_d = take ? rdata1 : '0;
    rd2_d = take ? rdata2 : '0;
    imm_d = take ? imm : '0;
    funct_d = take ? bus.id_inst[5:0] : '0;
    rs_d = take ? rs : '0;
    rt_d = take ? rt : '0;
    rd_d = take ? rd : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q <= CTRL_NOP;
      rd1_q <= '0;
      rd2_q <= '0;
      imm_q <= '0;
      funct_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q <= ctrl_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      imm_q <= imm_d;
      funct_q <= funct_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
      rd_q <= rd_d;
    end
  end
  assign bus.stall = stall;
  assign bus.ex_valid = valid_q;
  assign bus.ex_regData1 = rd1_q;
  assign bus.ex_regData2 = rd2_q;
  assign bus.ex_ext_immed = imm_q;
  assign bus.ex_funct = funct_q;
  assign bus.ex_rs = rs_q;
  assign bus.ex_rt = rt_q;
  assign bus.ex_rd = rd_q;
  assign bus.ex_ALUSrc = ctrl_q.alu_src;
  assign bus.ex_RegDst = ctrl_q.reg_dst;
  assign bus.ex_ALUOp = ctrl_q.alu_op;
  assign bus.ex_branch = ctrl_q.branch;
  assign bus.ex_MemWrite = ctrl_q.mem_write;
  assign bus.ex_MemRead = ctrl_q.mem_read;
  assign bus.ex_MemtoReg = ctrl_q.mem_to_reg;
  assign bus.ex_regWrite = ctrl_q.reg_write;
  assign bus.ex_illegal = ctrl_q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: scoreboard bench for id_stage_pipe, bypassing and non-bypassing instances
module tb_id_stage_pipe;
  typedef struct packed {
    logic valid;
    logic [31:0] rd1, rd2, rd1n, rd2n, imm;
    logic [5:0] funct;
    logic [4:0] rs, rt, rd;
    logic [9:0] ctrl;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t eq[$];
  logic sq[$];
  logic [31:0] m_rf [32];
  logic m_ev = 1'b0, m_emr = 1'b0, last_stall = 1'b0;
  logic [4:0] m_ert = '0;
  always #5 clk = ~clk;
  id_stage_pipe_if #(.XLEN(32), .AW(5)) bi ();
  id_stage_pipe_if #(.XLEN(32), .AW(5)) bn ();
  assign bn.id_inst = bi.id_inst;
  assign bn.id_valid = bi.id_valid;
  assign bn.flush = bi.flush;
  assign bn.wb_regWrite = bi.wb_regWrite;
  assign bn.wb_writeReg = bi.wb_writeReg;
  assign bn.wb_writeData = bi.wb_writeData;
  id_stage_pipe #(.XLEN(32), .AW(5), .BYPASS_EN(1'b1), .R0_ZERO(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(bi));
  id_stage_pipe #(.XLEN(32), .AW(5), .BYPASS_EN(1'b0), .R0_ZERO(1'b1)) u_nob (.clk(clk), .rst(rst), .bus(bn));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: stall is checked in its own cycle, ID/EX one cycle after the item was issued
  always @(negedge clk) begin
    exp_t e;
    if (sq.size() > 0) chk("stall", {31'b0, bi.stall}, {31'b0, sq.pop_front()});
    if (eq.size() > 1) begin
      e = eq.pop_front();
      chk("ex_valid", {31'b0, bi.ex_valid}, {31'b0, e.valid});
      chk("regData1", bi.ex_regData1, e.rd1);
      chk("regData2", bi.ex_regData2, e.rd2);
      chk("regData1_nobyp", bn.ex_regData1, e.rd1n);
      chk("regData2_nobyp", bn.ex_regData2, e.rd2n);
      chk("ext_immed", bi.ex_ext_immed, e.imm);
      chk("fields", {11'b0, bi.ex_funct, bi.ex_rs, bi.ex_rt, bi.ex_rd}, {11'b0, e.funct, e.rs, e.rt, e.rd});
      chk("ctrl", {22'b0, bi.ex_ALUSrc, bi.ex_RegDst, bi.ex_ALUOp, bi.ex_branch, bi.ex_MemWrite,
                   bi.ex_MemRead, bi.ex_MemtoReg, bi.ex_regWrite, bi.ex_illegal}, {22'b0, e.ctrl});
    end
  end
  task automatic step(input logic r, input logic [31:0] inst, input logic v, input logic f,
                      input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    exp_t e;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic ur, st;
    @(posedge clk);
    #1;
    rst = r;
    bi.id_inst = inst;
    bi.id_valid = v;
    bi.flush = f;
    bi.wb_regWrite = ww;
    bi.wb_writeReg = wr;
    bi.wb_writeData = wd;
    op = inst[31:26];
    rs = inst[25:21];
    rt = inst[20:16];
    ur = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04);
    st = !r && !f && m_ev && m_emr && (m_ert != 0) && v && ((m_ert == rs) || (ur && m_ert == rt));
    e = '0;
    if (!r && v && !f && !st) begin
      e.valid = 1'b1;
      e.rd1n = m_rf[rs];
      e.rd2n = m_rf[rt];
      e.rd1 = (ww && wr == rs && rs != 0) ? wd : e.rd1n;
      e.rd2 = (ww && wr == rt && rt != 0) ? wd : e.rd2n;
      e.imm = {{16{inst[15]}}, inst[15:0]};
      e.funct = inst[5:0];
      e.rs = rs;
      e.rt = rt;
      e.rd = inst[15:11];
      case (op)
        6'h00: e.ctrl = 10'b0_1_10_0_0_0_0_1_0;
        6'h23: e.ctrl = 10'b1_0_00_0_0_1_1_1_0;
        6'h2b: e.ctrl = 10'b1_0_00_0_1_0_0_0_0;
        6'h04: e.ctrl = 10'b0_0_01_1_0_0_0_0_0;
        default: e.ctrl = 10'b0_0_00_0_0_0_0_0_1;
      endcase
    end
    if (r) for (int i = 0; i < 32; i++) m_rf[i] = '0;
    else if (ww && wr != 0) m_rf[wr] = wd;
    m_ev = e.valid;
    m_emr = e.ctrl[3];
    m_ert = e.rt;
    last_stall = st;
    sq.push_back(st);
    eq.push_back(e);
  endtask
  initial begin
    logic [31:0] inst;
    logic [5:0] op;
    logic v;
    int k;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    bi.id_inst = '0;
    bi.id_valid = 1'b0;
    bi.flush = 1'b0;
    bi.wb_regWrite = 1'b0;
    bi.wb_writeReg = '0;
    bi.wb_writeData = '0;
    step(1, 32'h0, 0, 0, 0, 0, 0);
    step(1, 32'h0, 0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 1, 5'd9, 32'd5);
    step(0, 32'h0, 0, 0, 1, 5'd10, 32'd7);
    step(0, 32'h012A4020, 1, 0, 0, 0, 0);
    step(0, 32'h012A4020, 1, 0, 1, 5'd9, 32'h1234);
    step(0, 32'h8C220004, 1, 0, 1, 5'd4, 32'h55);
    step(0, 32'h00441820, 1, 0, 0, 0, 0);
    step(0, 32'h00441820, 1, 0, 0, 0, 0);
    step(0, 32'h8C220004, 1, 0, 0, 0, 0);
    step(0, 32'h00441820, 1, 1, 0, 0, 0);
    step(0, 32'h00441820, 1, 0, 0, 0, 0);
    step(0, 32'h00004020, 1, 0, 1, 5'd0, 32'hFFFF);
    step(0, 32'h00004020, 1, 0, 0, 0, 0);
    step(0, 32'hACC5FFFC, 1, 0, 1, 5'd6, 32'h100);
    step(0, 32'hFC000000, 1, 0, 0, 0, 0);
    step(0, 32'h8C220004, 1, 0, 0, 0, 0);
    step(1, 32'h00441820, 1, 0, 0, 0, 0);
    step(0, 32'h00441820, 0, 0, 0, 0, 0);
    inst = '0;
    v = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        k = $urandom_range(0, 4);
        op = (k == 0) ? 6'h00 : (k == 1) ? 6'h23 : (k == 2) ? 6'h2b : (k == 3) ? 6'h04 :
             ($urandom_range(0, 1) != 0) ? 6'h3f : 6'h02;
        inst = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        v = ($urandom_range(0, 6) != 0);
      end
      step($urandom_range(0, 49) == 0, inst, v, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom);
    end
    step(0, 32'h0, 0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
